// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the EX-stage forwarding / hazard controller.
// Shadow entry layout (LSB first): mem_read, reg_write, rd[REG_ADDR_W], valid.
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned SH_MEM_READ  = 0;
  localparam int unsigned SH_REG_WRITE = 1;
  localparam int unsigned SH_RD_LSB    = 2;

  function automatic int unsigned sh_valid_bit(input int unsigned addr_w);
    return addr_w + SH_RD_LSB;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_sel_calc.sv
// Combinational forward-select for one EX operand: youngest matching producer wins,
// x0 is never forwarded.
module fwd_sel_calc
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  use_rs,
  input  logic [REG_ADDR_W+2:0] ex_sh,
  input  logic [REG_ADDR_W+2:0] mem_sh,
  output logic [1:0]            sel
);

  localparam int unsigned VB = sh_valid_bit(REG_ADDR_W);

  function automatic logic hit(input logic [REG_ADDR_W+2:0] sh,
                               input logic [REG_ADDR_W-1:0] r,
                               input logic                  u);
    logic [REG_ADDR_W-1:0] rd;
    rd = sh[SH_RD_LSB +: REG_ADDR_W];
    return sh[VB] & sh[SH_REG_WRITE] & u &
           (rd != REG_ADDR_W'(REG_ZERO)) & (rd == r);
  endfunction

  logic unused_mem_read;
  assign unused_mem_read = ex_sh[SH_MEM_READ] ^ mem_sh[SH_MEM_READ];

  always_comb begin
    sel = FWD_REGFILE;
    if (hit(ex_sh, rs, use_rs))
      sel = FWD_EXMEM;
    else if (hit(mem_sh, rs, use_rs))
      sel = FWD_MEMWB;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forwarding selects, load-use stall and taken-branch flush control,
// with shadow copies of the EX and MEM destination info.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic                  ifid_flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned VB = sh_valid_bit(REG_ADDR_W);

  logic [REG_ADDR_W+2:0] id_sh, ex_sh, mem_sh;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [1:0]            a_next, b_next;
  logic                  load_use, stall, advance, branch;

  assign id_sh = {id_valid, id_rd, id_reg_write, id_mem_read};
  assign ex_rd = ex_sh[SH_RD_LSB +: REG_ADDR_W];

  assign load_use = id_valid & ex_sh[VB] & ex_sh[SH_MEM_READ] &
                    (ex_rd != REG_ADDR_W'(REG_ZERO)) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) |
                     (id_use_rs2 & (id_rs2 == ex_rd)));

  // Gated by rst_n so a branch input seen during reset cannot leak onto the flush/bubble outputs.
  assign branch  = rst_n & ex_branch_taken;
  assign stall   = load_use & ~branch;
  assign advance = id_valid & ~load_use & ~branch;

  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = rst_n & (load_use | branch);
  assign ifid_flush  = branch;

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs     (id_rs1),
    .use_rs (id_use_rs1),
    .ex_sh  (ex_sh),
    .mem_sh (mem_sh),
    .sel    (a_next)
  );

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs     (id_rs2),
    .use_rs (id_use_rs2),
    .ex_sh  (ex_sh),
    .mem_sh (mem_sh),
    .sel    (b_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_sh       <= '0;
      mem_sh      <= '0;
      fwd_a_sel   <= FWD_REGFILE;
      fwd_b_sel   <= FWD_REGFILE;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      mem_sh    <= ex_sh;
      ex_sh     <= advance ? id_sh : '0;
      fwd_a_sel <= advance ? a_next : FWD_REGFILE;
      fwd_b_sel <= advance ? b_next : FWD_REGFILE;
      if (stall && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (branch && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with a queue of expected forward selects.
module tb_fwd_hazard_ctrl;

  localparam int unsigned AW    = 5;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush;
  logic [CW-1:0] stall_count, flush_count;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_bubble     (idex_bubble),
    .ifid_flush      (ifid_flush),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic est, input logic ebr);
    chk({tag, ".pc_write"},    32'(pc_write),    32'(!est));
    chk({tag, ".ifid_write"},  32'(ifid_write),  32'(!est));
    chk({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(est | ebr));
    chk({tag, ".ifid_flush"},  32'(ifid_flush),  32'(ebr));
  endtask

  // One pipeline cycle: drive ID, check control, queue the selects expected after the edge.
  task automatic step(input string tag, input logic v,
                      input logic [AW-1:0] rs1, input logic u1,
                      input logic [AW-1:0] rs2, input logic u2,
                      input logic [AW-1:0] rd, input logic rw, input logic mr,
                      input logic br, input logic est, input logic ebr,
                      input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
    #1;
    chk_ctrl(tag, est, ebr);
    e.tag = tag; e.a = ea; e.b = eb;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".fwd_a_sel"}, 32'(fwd_a_sel), 32'(e.a));
      chk({e.tag, ".fwd_b_sel"}, 32'(fwd_b_sel), 32'(e.b));
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      step("idle", 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic chk_cnt(input string tag, input int es, input int ef);
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(es));
    chk({tag, ".flush_count"}, 32'(flush_count), 32'(ef));
  endtask

  initial begin
    #2;
    chk_ctrl("reset", 1'b0, 1'b0);
    chk("reset.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
    chk("reset.fwd_b_sel", 32'(fwd_b_sel), 32'd0);
    chk_cnt("reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load-use and taken branch in the same cycle: flush wins.
    step("br_lw",    1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    step("br_use",   1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 1, 0, 1, 2'b00, 2'b00);
    chk_cnt("br_cnt", 0, 1);
    idle(3);

    // Forwarding distance 1, 2, 3.
    step("add_x3",   1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("sub_d1",   1, 5'd3, 1, 5'd1, 1, 5'd7, 1, 0, 0, 0, 0, 2'b01, 2'b00);
    step("or_d2",    1, 5'd3, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, 0, 2'b10, 2'b00);
    step("and_d3",   1, 5'd3, 1, 5'd3, 1, 5'd9, 1, 0, 0, 0, 0, 2'b00, 2'b00);

    // x3 produced in both EX and MEM: youngest wins on rs2.
    step("add_x3a",  1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("add_x3b",  1, 5'd1, 1, 5'd1, 1, 5'd3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("dual",     1, 5'd1, 1, 5'd3, 1, 5'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01);
    idle(3);

    // Load-use stall then forward from MEM/WB.
    step("lw_x5",    1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    step("lu_stall", 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 1, 0, 2'b00, 2'b00);
    step("lu_adv",   1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 2'b10, 2'b10);
    chk_cnt("lu_cnt", 1, 1);
    idle(3);

    // x0 is never forwarded and never stalls.
    step("add_x0",   1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("use_x0a",  1, 5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    step("lw_x0",    1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    step("use_x0b",  1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    chk_cnt("x0_cnt", 1, 1);
    idle(2);

    // Flush counter saturation.
    for (int i = 0; i < 20; i++)
      step("br_sat", 0, '0, 0, '0, 0, '0, 0, 0, 1, 0, 1, 2'b00, 2'b00);
    chk_cnt("sat_cnt", 1, 15);
    idle(3);

    // Asynchronous reset in the middle of a stall.
    step("rs_lw",    1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    @(negedge clk);
    id_valid = 1; id_rs1 = 5'd5; id_use_rs1 = 1; id_rs2 = 5'd5; id_use_rs2 = 1;
    id_rd = 5'd6; id_reg_write = 1; id_mem_read = 0; ex_branch_taken = 0;
    #1;
    chk_ctrl("rs_stall", 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_ctrl("rs_async", 1'b0, 1'b0);
    chk("rs_async.fwd_a_sel", 32'(fwd_a_sel), 32'd0);
    chk("rs_async.fwd_b_sel", 32'(fwd_b_sel), 32'd0);
    chk_cnt("rs_async", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rs_after", 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    chk_cnt("rs_cnt", 0, 0);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
